decode_execute_stage: RTL and testbench

- Combined instruction-decode and execute stage of the single-cycle LEGv8 datapath.
- Sits between iFetch and iMemory/iWriteBack.
- Decodes a 32-bit instruction into control signals, a sign-extended immediate and an 11-bit opcode.
- Holds the 32x64-bit register file; computes ALU result, zero flag and branch target.

---
 rtl/decode_execute_if.sv | 42 ++++
 rtl/decode_execute_stage.sv | 187 ++++++++++++++++++
 tb/tb_decode_execute_stage.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/decode_execute_if.sv
// Bus between the LEGv8 decode/execute stage and its neighbouring stages.
// The master side supplies the instruction, PC and write-back value. The
// slave side (the stage) returns decode, register-read and ALU results.
interface decode_execute_if #(
  parameter int unsigned WORD      = 64,
  parameter int unsigned INSTR_LEN = 32
);
  logic [INSTR_LEN-1:0] instruction;
  logic [WORD-1:0]      cur_pc;
  logic [WORD-1:0]      write_data;

  logic [10:0]          opcode;
  logic [WORD-1:0]      sign_extended_output;
  logic                 reg2_loc;
  logic                 uncondbranch;
  logic                 branch;
  logic                 mem_read;
  logic                 mem_to_reg;
  logic                 mem_write;
  logic                 alu_src;
  logic                 reg_write;
  logic [1:0]           alu_op;
  logic [WORD-1:0]      read_data1;
  logic [WORD-1:0]      read_data2;
  logic [WORD-1:0]      branch_target;
  logic [WORD-1:0]      alu_result;
  logic                 zero;

  modport master (
    output instruction, cur_pc, write_data,
    input  opcode, sign_extended_output, reg2_loc, uncondbranch, branch,
           mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op,
           read_data1, read_data2, branch_target, alu_result, zero
  );

  modport slave (
    input  instruction, cur_pc, write_data,
    output opcode, sign_extended_output, reg2_loc, uncondbranch, branch,
           mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op,
           read_data1, read_data2, branch_target, alu_result, zero
  );
endinterface

// File: rtl/decode_execute_stage.sv
// Single-cycle LEGv8 decode + execute stage: instruction decode, immediate
// generation, 32x64 register file (X31 = XZR), ALU and branch target adder.
module decode_execute_stage #(
  parameter int unsigned WORD      = 64,
  parameter int unsigned INSTR_LEN = 32,
  parameter int unsigned NUM_REGS  = 32
) (
  input logic            clk,
  input logic            reset,
  decode_execute_if.slave bus
);

  typedef enum logic [3:0] {
    K_NONE, K_ADD, K_SUB, K_AND, K_ORR, K_ADDI, K_SUBI,
    K_LDUR, K_STUR, K_CBZ, K_B
  } instr_kind_e;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_ORR   = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SUB   = 4'b0110,
    ALU_PASSB = 4'b0111
  } alu_ctrl_e;

  localparam logic [4:0] XZR = 5'd31;

  logic [INSTR_LEN-1:0] instr;
  logic [10:0]          opcode;
  logic [4:0]           rd;
  logic [4:0]           rn;
  logic [4:0]           rm;
  logic [4:0]           rd2_addr;
  instr_kind_e          kind;
  alu_ctrl_e            alu_ctrl;

  logic                 reg2_loc, uncondbranch, branch, mem_read;
  logic                 mem_to_reg, mem_write, alu_src, reg_write;
  logic [1:0]           alu_op;
  logic [WORD-1:0]      imm;
  logic [WORD-1:0]      rdata1, rdata2, alu_b, alu_y;

  logic [WORD-1:0]      regs [NUM_REGS];

  assign instr    = bus.instruction;
  assign opcode   = instr[31:21];
  assign rd       = instr[4:0];
  assign rn       = instr[9:5];
  assign rm       = instr[20:16];
  assign rd2_addr = reg2_loc ? rd : rm;

  // Classify the instruction from its 11-bit opcode (low bits don't-care for I/CB/B).
  always_comb begin
    kind = K_NONE;
    casez (opcode)
      11'b10001011000: kind = K_ADD;
      11'b11001011000: kind = K_SUB;
      11'b10001010000: kind = K_AND;
      11'b10101010000: kind = K_ORR;
      11'b1001000100?: kind = K_ADDI;
      11'b1101000100?: kind = K_SUBI;
      11'b11111000010: kind = K_LDUR;
      11'b11111000000: kind = K_STUR;
      11'b10110100???: kind = K_CBZ;
      11'b000101?????: kind = K_B;
      default:         kind = K_NONE;
    endcase
  end

  // Main control signals and immediate generation per instruction class.
  always_comb begin
    reg2_loc     = 1'b0;
    alu_src      = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    branch       = 1'b0;
    uncondbranch = 1'b0;
    alu_op       = 2'b00;
    imm          = '0;
    unique case (kind)
      K_ADD, K_SUB, K_AND, K_ORR: begin
        reg_write = 1'b1;
        alu_op    = 2'b10;
      end
      K_ADDI, K_SUBI: begin
        alu_src   = 1'b1;
        reg_write = 1'b1;
        alu_op    = 2'b10;
        imm       = WORD'(instr[21:10]);
      end
      K_LDUR: begin
        alu_src    = 1'b1;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        mem_read   = 1'b1;
        imm        = WORD'($signed(instr[20:12]));
      end
      K_STUR: begin
        reg2_loc  = 1'b1;
        alu_src   = 1'b1;
        mem_write = 1'b1;
        imm       = WORD'($signed(instr[20:12]));
      end
      K_CBZ: begin
        reg2_loc = 1'b1;
        branch   = 1'b1;
        alu_op   = 2'b01;
        imm      = WORD'($signed(instr[23:5]));
      end
      K_B: begin
        reg2_loc     = 1'b1;
        uncondbranch = 1'b1;
        alu_op       = 2'b01;
        imm          = WORD'($signed(instr[25:0]));
      end
      default: ;
    endcase
  end

  // ALU control: class from alu_op, refined by opcode for R/I arithmetic.
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      2'b00: alu_ctrl = ALU_ADD;
      2'b01: alu_ctrl = ALU_PASSB;
      2'b10: begin
        case (kind)
          K_ADD, K_ADDI: alu_ctrl = ALU_ADD;
          K_SUB, K_SUBI: alu_ctrl = ALU_SUB;
          K_AND:         alu_ctrl = ALU_AND;
          K_ORR:         alu_ctrl = ALU_ORR;
          default:       alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

  // Asynchronous register reads; XZR always reads zero.
  always_comb begin
    rdata1 = (rn == XZR) ? '0 : regs[rn];
    rdata2 = (rd2_addr == XZR) ? '0 : regs[rd2_addr];
  end

  // 64-bit ALU with wrap-around arithmetic.
  always_comb begin
    alu_b = alu_src ? imm : rdata2;
    alu_y = rdata1 + alu_b;
    case (alu_ctrl)
      ALU_AND:   alu_y = rdata1 & alu_b;
      ALU_ORR:   alu_y = rdata1 | alu_b;
      ALU_ADD:   alu_y = rdata1 + alu_b;
      ALU_SUB:   alu_y = rdata1 - alu_b;
      ALU_PASSB: alu_y = alu_b;
      default:   alu_y = rdata1 + alu_b;
    endcase
  end

  // Register file write port; reset clears every register and wins over a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (reg_write && rd != XZR) begin
      regs[rd] <= bus.write_data;
    end
  end

  assign bus.opcode               = opcode;
  assign bus.sign_extended_output = imm;
  assign bus.reg2_loc             = reg2_loc;
  assign bus.uncondbranch         = uncondbranch;
  assign bus.branch               = branch;
  assign bus.mem_read             = mem_read;
  assign bus.mem_to_reg           = mem_to_reg;
  assign bus.mem_write            = mem_write;
  assign bus.alu_src              = alu_src;
  assign bus.reg_write            = reg_write;
  assign bus.alu_op               = alu_op;
  assign bus.read_data1           = rdata1;
  assign bus.read_data2           = rdata2;
  assign bus.branch_target        = bus.cur_pc + (imm << 2);
  assign bus.alu_result           = alu_y;
  assign bus.zero                 = (alu_y == '0);

endmodule

// File: tb/tb_decode_execute_stage.sv
// Directed self-checking bench for decode_execute_stage.
module tb_decode_execute_stage;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  logic clk = 1'b0;
  logic reset;
  int   tests_run    = 0;
  int   tests_failed = 0;

  decode_execute_if #(.WORD(64), .INSTR_LEN(32)) bus ();

  decode_execute_stage #(.WORD(64), .INSTR_LEN(32), .NUM_REGS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(logic [10:0] opc, logic [4:0] rm, logic [4:0] rn, logic [4:0] rd);
    return {opc, rm, 6'd0, rn, rd};
  endfunction

  function automatic logic [31:0] enc_i(logic [9:0] opc, logic [11:0] imm, logic [4:0] rn, logic [4:0] rd);
    return {opc, imm, rn, rd};
  endfunction

  function automatic logic [31:0] enc_d(logic [10:0] opc, logic [8:0] imm, logic [4:0] rn, logic [4:0] rt);
    return {opc, imm, 2'b00, rn, rt};
  endfunction

  function automatic logic [31:0] enc_cb(logic [7:0] opc, logic [18:0] imm, logic [4:0] rt);
    return {opc, imm, rt};
  endfunction

  function automatic logic [31:0] enc_b(logic [5:0] opc, logic [25:0] imm);
    return {opc, imm};
  endfunction

  // {reg2_loc, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, uncondbranch, alu_op}
  function automatic logic [9:0] ctl();
    return {bus.reg2_loc, bus.alu_src, bus.mem_to_reg, bus.reg_write, bus.mem_read,
            bus.mem_write, bus.branch, bus.uncondbranch, bus.alu_op};
  endfunction

  task automatic apply(input logic [31:0] ins, input logic [63:0] pc, input logic [63:0] wd);
    bus.instruction = ins;
    bus.cur_pc      = pc;
    bus.write_data  = wd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observe X[n] through read_data1 of ADD X0,Xn,XZR (never clocked).
  task automatic read_reg(input string tag, input logic [4:0] n, input logic [63:0] exp);
    apply(enc_r(OP_ADD, 5'd31, n, 5'd0), 64'd0, 64'd0);
    check(tag, bus.read_data1, exp);
  endtask

  initial begin
    reset = 1'b1;
    apply(32'h0, 64'd0, 64'd0);
    tick();
    reset = 1'b0;

    // Reset state seen through ADD X0,X1,X2
    apply(32'h8B020020, 64'd0, 64'd0);
    check("add_opcode", 64'(bus.opcode), 64'(OP_ADD));
    check("rst_rd1", bus.read_data1, 64'd0);
    check("rst_rd2", bus.read_data2, 64'd0);
    check("rst_alu", bus.alu_result, 64'd0);
    check("rst_zero", 64'(bus.zero), 64'd1);
    check("add_ctl", 64'(ctl()), 64'(10'b0001000010));

    // Unknown opcode: everything off
    apply(32'h0000_0000, 64'd0, 64'd0);
    check("unk_ctl", 64'(ctl()), 64'd0);
    check("unk_imm", bus.sign_extended_output, 64'd0);

    // ADDI X9,XZR,#56
    apply(32'h9100E3E9, 64'd0, 64'd56);
    check("addi_ctl", 64'(ctl()), 64'(10'b0101000010));
    check("addi_imm", bus.sign_extended_output, 64'd56);
    check("addi_alu", bus.alu_result, 64'd56);
    tick();
    read_reg("x9_56", 5'd9, 64'd56);

    // ADDI X10,XZR,#8
    apply(enc_i(OP_ADDI, 12'd8, 5'd31, 5'd10), 64'd0, 64'd8);
    check("addi10_alu", bus.alu_result, 64'd8);
    tick();
    read_reg("x10_8", 5'd10, 64'd8);

    // Countdown loop: SUB X9,X9,X10 / ADDI X11,X11,#1, 7 times
    for (int i = 0; i < 7; i++) begin
      apply(enc_r(OP_SUB, 5'd10, 5'd9, 5'd9), 64'd0, 64'd0);
      check("loop_sub", bus.alu_result, 64'(56 - 8 * (i + 1)));
      bus.write_data = bus.alu_result;
      tick();
      apply(enc_i(OP_ADDI, 12'd1, 5'd11, 5'd11), 64'd0, 64'd0);
      bus.write_data = bus.alu_result;
      tick();
    end
    read_reg("x11_7", 5'd11, 64'd7);

    // CBZ X9 after the loop: X9 == 0
    apply(enc_cb(OP_CBZ, 19'd3, 5'd9), 64'h10, 64'd0);
    check("cbz9_ctl", 64'(ctl()), 64'(10'b1000001001));
    check("cbz9_zero", 64'(bus.zero), 64'd1);

    // ADDI X2,XZR,#100; ADDI X3,XZR,#5
    apply(enc_i(OP_ADDI, 12'd100, 5'd31, 5'd2), 64'd0, 64'd100);
    tick();
    apply(enc_i(OP_ADDI, 12'd5, 5'd31, 5'd3), 64'd0, 64'd5);
    tick();

    // LDUR X1,[X2,#-8]
    apply(enc_d(OP_LDUR, 9'h1F8, 5'd2, 5'd1), 64'd0, 64'd0);
    check("ldur_imm", bus.sign_extended_output, 64'hFFFF_FFFF_FFFF_FFF8);
    check("ldur_ctl", 64'(ctl()), 64'(10'b0111100000));
    check("ldur_alu", bus.alu_result, 64'd92);

    // STUR X3,[X2,#16]: reads Rt on read_data2, must not write X3
    apply(enc_d(OP_STUR, 9'd16, 5'd2, 5'd3), 64'd0, 64'hDEAD);
    check("stur_ctl", 64'(ctl()), 64'(10'b1100010000));
    check("stur_rd2", bus.read_data2, 64'd5);
    check("stur_alu", bus.alu_result, 64'd116);
    tick();
    read_reg("stur_nowr", 5'd3, 64'd5);

    // B #-2 at 0x40
    apply(enc_b(OP_B, 26'h3FF_FFFE), 64'h40, 64'd0);
    check("b_ctl", 64'(ctl()), 64'(10'b1000000101));
    check("b_target", bus.branch_target, 64'h38);

    // CBZ X3,#3 at 0x10 with X3 = 5
    apply(enc_cb(OP_CBZ, 19'd3, 5'd3), 64'h10, 64'd0);
    check("cbz3_branch", 64'(bus.branch), 64'd1);
    check("cbz3_zero", 64'(bus.zero), 64'd0);
    check("cbz3_alu", bus.alu_result, 64'd5);
    check("cbz3_target", bus.branch_target, 64'h1C);

    // Logical ops and wrap-around
    apply(enc_r(OP_ORR, 5'd3, 5'd10, 5'd4), 64'd0, 64'd0);
    check("orr_alu", bus.alu_result, 64'd13);
    apply(enc_r(OP_AND, 5'd3, 5'd2, 5'd4), 64'd0, 64'd0);
    check("and_alu", bus.alu_result, 64'd4);
    apply(enc_i(OP_SUBI, 12'd1, 5'd31, 5'd5), 64'd0, 64'd0);
    check("subi_wrap", bus.alu_result, 64'hFFFF_FFFF_FFFF_FFFF);
    apply(enc_b(OP_B, 26'h200_0000), 64'h0, 64'd0);
    check("b_wrap", bus.branch_target, 64'hFFFF_FFFF_F800_0000);

    // ADDI X31,XZR,#5 is ignored
    apply(enc_i(OP_ADDI, 12'd5, 5'd31, 5'd31), 64'd0, 64'd5);
    check("xzr_alu", bus.alu_result, 64'd5);
    tick();
    read_reg("xzr_zero", 5'd31, 64'd0);

    // Reset mid-program suppresses a concurrent write and clears registers
    apply(enc_i(OP_ADDI, 12'd56, 5'd31, 5'd9), 64'd0, 64'd56);
    tick();
    read_reg("x9_pre_rst", 5'd9, 64'd56);
    reset = 1'b1;
    apply(enc_i(OP_ADDI, 12'd7, 5'd31, 5'd9), 64'd0, 64'd7);
    tick();
    reset = 1'b0;
    read_reg("x9_post_rst", 5'd9, 64'd0);
    read_reg("x10_post_rst", 5'd10, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
